board_controller: RTL and testbench

- Game-sequencing controller that owns the 5x5 board state and cursor position driven into the VGA display block.
- Turns button presses into cursor moves and marker placements, and alternates players 1 and 2.
- After each placement, sequentially scans the board for a winning line or a full-board draw, then holds the result until a new game is requested.

---
 rtl/board_controller.sv | 180 ++++++++++++++++++
 tb/tb_board_controller.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_controller.sv
// Game sequencer for a 5x5 board: cursor moves, marker placement, turn order and win/draw scan.
// States: PLAY (accept moves/places) | CHECK (scan one start cell per cycle) | DONE (result held).
module board_controller #(
    parameter int WIN_LEN     = 4,
    parameter int CURSOR_WRAP = 1
) (
    input  logic        clk_display,
    input  logic        clr_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    input  logic        new_game,
    output logic [74:0] board_flat,
    output logic [2:0]  cursor_row,
    output logic [2:0]  cursor_col,
    output logic [1:0]  current_player,
    output logic        busy,
    output logic [1:0]  winner
);

    localparam logic [1:0] S_PLAY  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [74:0] board_q,  board_d;
    logic [2:0]  row_q,    row_d;
    logic [2:0]  col_q,    col_d;
    logic [1:0]  player_q, player_d;
    logic [1:0]  winner_q, winner_d;
    logic [4:0]  moves_q,  moves_d;
    logic [4:0]  scan_q,   scan_d;
    logic [4:0]  hist_q;

    logic [4:0] btn_vec;
    logic [4:0] ev;
    logic [2:0] cells [25];
    logic [4:0] cur_idx;
    logic       hit;

    // Bit order: 0 up, 1 down, 2 left, 3 right, 4 place
    assign btn_vec = {btn_place, btn_right, btn_left, btn_down, btn_up};
    assign ev      = btn_vec & ~hist_q;
    assign cur_idx = {2'b00, row_q} * 5'd5 + {2'b00, col_q};

    always_comb begin
        for (int i = 0; i < 25; i++) begin
            cells[i] = board_q[3*i +: 3];
        end
    end

    function automatic logic [2:0] step_dec(input logic [2:0] v);
        if (v == 3'd0) return (CURSOR_WRAP != 0) ? 3'd4 : 3'd0;
        return v - 3'd1;
    endfunction

    function automatic logic [2:0] step_inc(input logic [2:0] v);
        if (v == 3'd4) return (CURSOR_WRAP != 0) ? 3'd0 : 3'd4;
        return v + 3'd1;
    endfunction

    // Signed coordinates so that stepping left from column 0 leaves the board instead of wrapping
    always_comb begin
        int  r0, c0, rr, cc, dr, dc;
        logic run;
        hit = 1'b0;
        r0  = int'(scan_q) / 5;
        c0  = int'(scan_q) % 5;
        for (int d = 0; d < 4; d++) begin
            dr  = (d == 0) ? 0 : 1;
            dc  = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
            run = 1'b1;
            for (int k = 0; k < WIN_LEN; k++) begin
                rr = r0 + k * dr;
                cc = c0 + k * dc;
                if (rr < 0 || rr > 4 || cc < 0 || cc > 4) begin
                    run = 1'b0;
                end else if (cells[5'(rr * 5 + cc)] != {1'b0, player_q}) begin
                    run = 1'b0;
                end
            end
            if (run) hit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        row_d    = row_q;
        col_d    = col_q;
        player_d = player_q;
        winner_d = winner_q;
        moves_d  = moves_q;
        scan_d   = scan_q;
        if (new_game) begin
            state_d  = S_PLAY;
            board_d  = '0;
            row_d    = 3'd2;
            col_d    = 3'd2;
            player_d = 2'd1;
            winner_d = 2'd0;
            moves_d  = 5'd0;
            scan_d   = 5'd0;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (ev[4]) begin
                        if (cells[cur_idx] == 3'd0) begin
                            board_d[7'd3 * {2'b00, cur_idx} +: 3] = {1'b0, player_q};
                            moves_d = moves_q + 5'd1;
                            scan_d  = 5'd0;
                            state_d = S_CHECK;
                        end
                    end else if (ev[0]) begin
                        row_d = step_dec(row_q);
                    end else if (ev[1]) begin
                        row_d = step_inc(row_q);
                    end else if (ev[2]) begin
                        col_d = step_dec(col_q);
                    end else if (ev[3]) begin
                        col_d = step_inc(col_q);
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        winner_d = player_q;
                        state_d  = S_DONE;
                    end else if (scan_q == 5'd24) begin
                        if (moves_q == 5'd25) begin
                            winner_d = 2'd3;
                            state_d  = S_DONE;
                        end else begin
                            player_d = (player_q == 2'd1) ? 2'd2 : 2'd1;
                            state_d  = S_PLAY;
                        end
                    end else begin
                        scan_d = scan_q + 5'd1;
                    end
                end
                S_DONE: begin
                end
                default: state_d = S_PLAY;
            endcase
        end
    end

    always_ff @(posedge clk_display or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_PLAY;
            board_q  <= '0;
            row_q    <= 3'd2;
            col_q    <= 3'd2;
            player_q <= 2'd1;
            winner_q <= 2'd0;
            moves_q  <= 5'd0;
            scan_q   <= 5'd0;
            hist_q   <= 5'd0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            row_q    <= row_d;
            col_q    <= col_d;
            player_q <= player_d;
            winner_q <= winner_d;
            moves_q  <= moves_d;
            scan_q   <= scan_d;
            hist_q   <= btn_vec;
        end
    end

    assign board_flat     = board_q;
    assign cursor_row     = row_q;
    assign cursor_col     = col_q;
    assign current_player = player_q;
    assign winner         = winner_q;
    assign busy           = (state_q == S_CHECK);

endmodule

// File: tb/tb_board_controller.sv
// Randomised and directed bench for board_controller; a game-level model feeds a scoreboard.
// The monitor compares DUT outputs against queued expectations whenever the stimulus marks a settle point.
module tb_board_controller;

    localparam int WIN = 4;

    logic        clk_display = 1'b0;
    logic        clr_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_place, new_game;
    logic [74:0] board_flat;
    logic [2:0]  cursor_row, cursor_col;
    logic [1:0]  current_player, winner;
    logic        busy;

    board_controller #(.WIN_LEN(WIN), .CURSOR_WRAP(1)) dut (
        .clk_display    (clk_display),
        .clr_n          (clr_n),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_place      (btn_place),
        .new_game       (new_game),
        .board_flat     (board_flat),
        .cursor_row     (cursor_row),
        .cursor_col     (cursor_col),
        .current_player (current_player),
        .busy           (busy),
        .winner         (winner)
    );

    always #5 clk_display = ~clk_display;

    typedef struct {
        logic [74:0] board;
        int          row;
        int          col;
        int          player;
        int          winner;
        int          busy_len;
        bit          chk_busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_req = 1'b0;

    // Event bits: 0 up, 1 down, 2 left, 3 right, 4 place, 5 new_game
    localparam logic [5:0] EV_UP = 6'd1, EV_DN = 6'd2, EV_LT = 6'd4, EV_RT = 6'd8;
    localparam logic [5:0] EV_PL = 6'd16, EV_NG = 6'd32;

    int m_board [25];
    int m_row, m_col, m_player, m_winner, m_moves;
    bit m_done;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 25; i++) m_board[i] = 0;
        m_row = 2; m_col = 2; m_player = 1; m_winner = 0; m_moves = 0; m_done = 0;
    endtask

    // A line starting at s wins if its far end is on the board and every cell holds the mover
    function automatic bit m_win_at(input int s);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        int r = s / 5;
        int c = s % 5;
        for (int d = 0; d < 4; d++) begin
            int er = r + (WIN - 1) * dr[d];
            int ec = c + (WIN - 1) * dc[d];
            bit all_mine = 1;
            if (er < 0 || er > 4 || ec < 0 || ec > 4) continue;
            for (int k = 0; k < WIN; k++)
                if (m_board[(r + k * dr[d]) * 5 + c + k * dc[d]] != m_player) all_mine = 0;
            if (all_mine) return 1;
        end
        return 0;
    endfunction

    task automatic m_apply(input logic [5:0] ev, output int blen);
        blen = 0;
        if (ev[5]) begin
            m_reset();
        end else if (m_done) begin
        end else if (ev[4]) begin
            if (m_board[m_row * 5 + m_col] == 0) begin
                bit won = 0;
                m_board[m_row * 5 + m_col] = m_player;
                m_moves++;
                blen = 25;
                for (int s = 0; s < 25 && !won; s++)
                    if (m_win_at(s)) begin won = 1; blen = s + 1; end
                if (won) begin m_winner = m_player; m_done = 1; end
                else if (m_moves == 25) begin m_winner = 3; m_done = 1; end
                else m_player = 3 - m_player;
            end
        end else if (ev[0]) m_row = (m_row + 4) % 5;
        else if (ev[1]) m_row = (m_row + 1) % 5;
        else if (ev[2]) m_col = (m_col + 4) % 5;
        else if (ev[3]) m_col = (m_col + 1) % 5;
    endtask

    function automatic logic [74:0] m_flat();
        logic [74:0] f = '0;
        for (int i = 0; i < 25; i++) f[3*i +: 3] = 3'(m_board[i]);
        return f;
    endfunction

    task automatic push_exp(input bit chk_busy, input int blen);
        exp_t e;
        e.board = m_flat(); e.row = m_row; e.col = m_col; e.player = m_player;
        e.winner = m_winner; e.busy_len = blen; e.chk_busy = chk_busy;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] ev);
        btn_up = ev[0]; btn_down = ev[1]; btn_left = ev[2]; btn_right = ev[3];
        btn_place = ev[4]; new_game = ev[5];
    endtask

    task automatic settle();
        int t = 0;
        while (busy && t < 40) begin @(negedge clk_display); t++; end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL settle_timeout: busy still %0d, required 0", busy);
        end
    endtask

    task automatic request();
        int t = 0;
        @(posedge clk_display); #1 chk_req = 1'b1;
        while (chk_req && t < 5) begin @(negedge clk_display); #1; t++; end
        if (chk_req) begin
            n_cmp++; n_err++;
            $display("FAIL monitor_timeout: request pending %0d, required 0", chk_req);
            chk_req = 1'b0;
        end
    endtask

    task automatic do_action(input logic [5:0] ev, input int hold);
        int blen;
        @(negedge clk_display);
        drive(ev);
        m_apply(ev, blen);
        repeat (hold) @(negedge clk_display);
        drive(6'd0);
        settle();
        push_exp(1, blen);
        request();
    endtask

    task automatic goto_cell(input int idx);
        int g = 0;
        while (m_row != idx / 5 && g < 10) begin do_action(EV_DN, 1); g++; end
        while (m_col != idx % 5 && g < 20) begin do_action(EV_RT, 1); g++; end
    endtask

    task automatic place_at(input int idx);
        goto_cell(idx);
        do_action(EV_PL, 1);
    endtask

    initial begin : monitor
        int   run;
        int   last_len;
        exp_t e;
        run = 0;
        last_len = 0;
        forever begin
            @(negedge clk_display);
            if (busy) run++;
            else begin
                if (run > 0) last_len = run;
                run = 0;
            end
            if (chk_req) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL scoreboard_empty: got 0 entries, required 1");
                end else begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    if (board_flat !== e.board) begin
                        n_err++;
                        $display("FAIL board: got %h expected %h at %0t", board_flat, e.board, $time);
                    end
                    cmp("cursor_row", int'(cursor_row), e.row);
                    cmp("cursor_col", int'(cursor_col), e.col);
                    cmp("player", int'(current_player), e.player);
                    cmp("winner", int'(winner), e.winner);
                    cmp("busy_idle", int'(busy), 0);
                    if (e.chk_busy) cmp("busy_len", last_len, e.busy_len);
                end
                last_len = 0;
                chk_req = 1'b0;
            end
        end
    end

    int win_row  [7]  = '{0, 20, 1, 21, 2, 22, 3};
    int win_diag [10] = '{24, 0, 23, 4, 19, 8, 14, 12, 22, 16};

    initial begin : stimulus
        int p1 [$];
        int p2 [$];
        int blen;
        clr_n = 1'b0;
        drive(6'd0);
        m_reset();
        repeat (3) @(negedge clk_display);
        clr_n = 1'b1;
        push_exp(1, 0);
        request();

        // Cursor wrap and held-button single step
        repeat (3) do_action(EV_RT, 1);
        cmp("wrap_col", int'(cursor_col), 0);
        do_action(EV_RT, 3);

        // Place, interfering presses during CHECK, repeat place on occupied cell
        do_action(EV_NG, 1);
        @(negedge clk_display);
        drive(EV_PL);
        m_apply(EV_PL, blen);
        @(negedge clk_display);
        drive(6'd0);
        repeat (3) @(negedge clk_display);
        drive(EV_PL | EV_RT);
        @(negedge clk_display);
        drive(6'd0);
        settle();
        push_exp(1, blen);
        request();
        cmp("cell_2_2", int'(board_flat[38:36]), 1);
        do_action(EV_PL, 1);

        // Row win for player 1, then moves in DONE are ignored
        do_action(EV_NG, 1);
        foreach (win_row[i]) place_at(win_row[i]);
        do_action(EV_DN, 1);
        do_action(EV_PL, 1);

        // Down-left diagonal win for player 2, with a column-0 start that must not wrap
        do_action(EV_NG, 1);
        foreach (win_diag[i]) place_at(win_diag[i]);

        // Full board with no run of four: draw
        do_action(EV_NG, 1);
        for (int i = 0; i < 25; i++) begin
            if (((i % 5) + 2 * (i / 5)) % 4 < 2) p1.push_back(i);
            else p2.push_back(i);
        end
        for (int i = 0; i < 13; i++) begin
            place_at(p1[i]);
            if (i < 12) place_at(p2[i]);
        end

        // new_game while CHECK is running
        do_action(EV_NG, 1);
        goto_cell(6);
        @(negedge clk_display);
        drive(EV_PL);
        m_apply(EV_PL, blen);
        @(negedge clk_display);
        drive(6'd0);
        repeat (5) @(negedge clk_display);
        drive(EV_NG);
        m_reset();
        push_exp(0, 0);
        @(posedge clk_display); #1 chk_req = 1'b1;
        @(negedge clk_display); #1;
        drive(6'd0);
        if (chk_req) begin
            n_cmp++; n_err++;
            $display("FAIL ng_monitor_timeout: request pending %0d, required 0", chk_req);
            chk_req = 1'b0;
        end

        // Asynchronous reset while CHECK is running
        goto_cell(18);
        @(negedge clk_display);
        drive(EV_PL);
        m_apply(EV_PL, blen);
        @(negedge clk_display);
        drive(6'd0);
        repeat (4) @(negedge clk_display);
        #2 clr_n = 1'b0;
        #1;
        n_cmp++;
        if (board_flat !== 75'd0) begin
            n_err++;
            $display("FAIL async_board: got %h expected 0", board_flat);
        end
        cmp("async_row", int'(cursor_row), 2);
        cmp("async_col", int'(cursor_col), 2);
        cmp("async_player", int'(current_player), 1);
        cmp("async_winner", int'(winner), 0);
        cmp("async_busy", int'(busy), 0);
        @(negedge clk_display);
        clr_n = 1'b1;
        m_reset();
        push_exp(0, 0);
        request();

        // Random play
        for (int n = 0; n < 250; n++) begin
            int r = $urandom_range(0, 99);
            logic [5:0] ev;
            if (r < 2) ev = EV_NG;
            else if (r < 40) ev = EV_PL;
            else if (r < 85) ev = 6'(1 << $urandom_range(0, 3));
            else ev = 6'($urandom_range(1, 31));
            do_action(ev, $urandom_range(1, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
